// File: rtl/microsequencer.sv
// Microprogram next-state engine: picks the following microstate from the
// sequencing fields of the current control word and registers it.
module microsequencer #(
  parameter int unsigned FETCH_STATE = 1,
  parameter int unsigned UNDEF_STATE = 45,
  parameter int unsigned FAULT_STATE = 46,
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ms_op,
  input  logic [9:0]  ms_cr,
  input  logic        ms_inv,
  input  logic [31:0] ir,
  input  logic        cond_true,
  input  logic        mfc,
  output logic [9:0]  next_state,
  output logic        waiting,
  output logic        fault,
  output logic [7:0]  wait_cnt
);

  localparam int unsigned SW  = 10;
  localparam int unsigned CW  = 8;
  localparam int unsigned IRW = 32;

  typedef enum logic [2:0] {
    OP_FETCH      = 3'd0,
    OP_INC        = 3'd1,
    OP_JUMP       = 3'd2,
    OP_DECODE     = 3'd3,
    OP_WAIT_MFC   = 3'd4,
    OP_COND_BR    = 3'd5,
    OP_COND_FETCH = 3'd6,
    OP_RSVD       = 3'd7
  } ms_op_e;

  logic [SW-1:0] r_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_fault;

  ms_op_e        w_op;
  logic [SW-1:0] w_state_inc;
  logic [SW-1:0] w_state_nxt;
  logic [SW-1:0] w_dec_state;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_fault_set;
  logic          w_take;
  logic          w_timeout;
  logic          w_unused_ir;

  // Instruction class decode into the first microstate of its handler
  function automatic logic [SW-1:0] enc(input logic [IRW-1:0] ir_v);
    logic [SW-1:0] res;
    case (ir_v[27:25])
      3'b000:  res = ir_v[4] ? SW'(11) : SW'(10);
      3'b001:  res = SW'(12);
      3'b010:  res = ir_v[20] ? SW'(20) : SW'(30);
      3'b011:  res = ir_v[4] ? SW'(UNDEF_STATE) : (ir_v[20] ? SW'(22) : SW'(32));
      3'b101:  res = SW'(42);
      default: res = SW'(UNDEF_STATE);
    endcase
    return res;
  endfunction

  assign w_op        = ms_op_e'(ms_op);
  assign w_state_inc = r_state + SW'(1);
  assign w_dec_state = enc(ir);
  assign w_take      = cond_true ^ ms_inv;
  assign w_cnt_inc   = (r_wait_cnt == {CW{1'b1}}) ? r_wait_cnt : r_wait_cnt + CW'(1);
  assign w_timeout   = (r_wait_cnt == CW'(MFC_TIMEOUT - 1));
  assign w_unused_ir = ^{ir[31:28], ir[24:21], ir[19:5], ir[3:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_fault_set = 1'b0;
    case (w_op)
      OP_FETCH:      w_state_nxt = SW'(FETCH_STATE);
      OP_INC:        w_state_nxt = w_state_inc;
      OP_JUMP:       w_state_nxt = ms_cr;
      OP_DECODE:     w_state_nxt = w_dec_state;
      OP_WAIT_MFC: begin
        // A completing MFC wins over an expiring timeout
        if (mfc) begin
          w_state_nxt = w_state_inc;
        end else if (w_timeout) begin
          w_state_nxt = SW'(FAULT_STATE);
          w_fault_set = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      OP_COND_BR:    w_state_nxt = w_take ? ms_cr : w_state_inc;
      OP_COND_FETCH: w_state_nxt = w_take ? SW'(FETCH_STATE) : w_state_inc;
      default:       w_state_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= '0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      if (w_fault_set) r_fault <= 1'b1;
    end
  end

  assign next_state = r_state;
  assign wait_cnt   = r_wait_cnt;
  assign fault      = r_fault;
  assign waiting    = (w_op == OP_WAIT_MFC) & ~mfc & ~reset;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: each driven cycle queues its expected
// post-edge state, popped and compared one edge later.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ms_op;
  logic [9:0]  ms_cr;
  logic        ms_inv;
  logic [31:0] ir;
  logic        cond_true;
  logic        mfc;
  logic [9:0]  next_state;
  logic        waiting;
  logic        fault;
  logic [7:0]  wait_cnt;

  typedef struct {
    string      tag;
    logic [9:0] st;
    logic [7:0] cnt;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  microsequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ms_op      (ms_op),
    .ms_cr      (ms_cr),
    .ms_inv     (ms_inv),
    .ir         (ir),
    .cond_true  (cond_true),
    .mfc        (mfc),
    .next_state (next_state),
    .waiting    (waiting),
    .fault      (fault),
    .wait_cnt   (wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle, check waiting before the edge, score the result after it
  task automatic step(input string tag, input logic rst, input logic [2:0] op,
                      input logic [9:0] cr, input logic inv, input logic cnd,
                      input logic m, input logic [31:0] ir_v,
                      input logic [9:0] e_st, input logic [7:0] e_cnt, input logic e_flt);
    exp_t e;
    reset = rst; ms_op = op; ms_cr = cr; ms_inv = inv;
    cond_true = cnd; mfc = m; ir = ir_v;
    #1;
    check_val({tag, ".waiting"}, 32'(waiting), 32'((op == 3'd4) && !m && !rst));
    e.tag = tag; e.st = e_st; e.cnt = e_cnt; e.flt = e_flt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      check_val({e.tag, ".state"}, 32'(next_state), 32'(e.st));
      check_val({e.tag, ".wait_cnt"}, 32'(wait_cnt), 32'(e.cnt));
      check_val({e.tag, ".fault"}, 32'(fault), 32'(e.flt));
    end
  endtask

  task automatic simple(input string tag, input logic [2:0] op, input logic [9:0] cr,
                        input logic [9:0] e_st, input logic e_flt);
    step(tag, 1'b0, op, cr, 1'b0, 1'b0, 1'b0, 32'h0, e_st, 8'd0, e_flt);
  endtask

  task automatic decode(input string tag, input logic [31:0] ir_v, input logic [9:0] e_st);
    step(tag, 1'b0, 3'd3, 10'd0, 1'b0, 1'b0, 1'b0, ir_v, e_st, 8'd0, 1'b0);
  endtask

  task automatic stall(input string tag, input logic [9:0] e_st, input logic [7:0] e_cnt,
                       input logic e_flt);
    step(tag, 1'b0, 3'd4, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0, e_st, e_cnt, e_flt);
  endtask

  initial begin
    reset = 1'b1; ms_op = 3'd1; ms_cr = '0; ms_inv = 1'b0;
    cond_true = 1'b0; mfc = 1'b0; ir = '0;
    @(posedge clk);
    #1;

    // Reset then increment
    step("rst0", 1'b1, 3'd1, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 8'd0, 1'b0);
    step("rst1", 1'b1, 3'd1, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 8'd0, 1'b0);
    simple("inc1", 3'd1, 10'd0, 10'd1, 1'b0);
    simple("inc2", 3'd1, 10'd0, 10'd2, 1'b0);

    // Normal MFC wait
    for (int i = 1; i <= 4; i++) stall($sformatf("wait%0d", i), 10'd2, 8'(i), 1'b0);
    step("wait_done", 1'b0, 3'd4, 10'd0, 1'b0, 1'b0, 1'b1, 32'h0, 10'd3, 8'd0, 1'b0);

    // Instruction decode table
    decode("dec_ldr_imm", 32'hE590_0000, 10'd20);
    decode("dec_str_imm", 32'hE580_0000, 10'd30);
    decode("dec_branch",  32'hEA00_0004, 10'd42);
    decode("dec_undef3",  32'hE600_0010, 10'd45);
    decode("dec_dp",      32'hE000_0000, 10'd10);
    decode("dec_dp_rs",   32'hE000_0010, 10'd11);
    decode("dec_dp_imm",  32'hE200_0000, 10'd12);
    decode("dec_ldr_reg", 32'hE790_0000, 10'd22);
    decode("dec_str_reg", 32'hE780_0000, 10'd32);
    decode("dec_cls4",    32'hE800_0000, 10'd45);

    // Conditional branch / fetch
    simple("j41a", 3'd2, 10'd41, 10'd41, 1'b0);
    step("cbr_t", 1'b0, 3'd5, 10'd3, 1'b0, 1'b1, 1'b0, 32'h0, 10'd3, 8'd0, 1'b0);
    simple("j41b", 3'd2, 10'd41, 10'd41, 1'b0);
    step("cbr_f", 1'b0, 3'd5, 10'd3, 1'b0, 1'b0, 1'b0, 32'h0, 10'd42, 8'd0, 1'b0);
    simple("j41c", 3'd2, 10'd41, 10'd41, 1'b0);
    step("cbr_inv", 1'b0, 3'd5, 10'd3, 1'b1, 1'b0, 1'b0, 32'h0, 10'd3, 8'd0, 1'b0);
    simple("j41d", 3'd2, 10'd41, 10'd41, 1'b0);
    step("cf_not", 1'b0, 3'd6, 10'd0, 1'b1, 1'b1, 1'b0, 32'h0, 10'd42, 8'd0, 1'b0);
    step("cf_take", 1'b0, 3'd6, 10'd0, 1'b1, 1'b0, 1'b0, 32'h0, 10'd1, 8'd0, 1'b0);
    simple("j7", 3'd2, 10'd7, 10'd7, 1'b0);
    simple("fetch", 3'd0, 10'd0, 10'd1, 1'b0);
    simple("rsvd", 3'd7, 10'd9, 10'd0, 1'b0);

    // MFC timeout sets sticky fault
    simple("j2t", 3'd2, 10'd2, 10'd2, 1'b0);
    for (int i = 1; i <= 14; i++) stall($sformatf("to%0d", i), 10'd2, 8'(i), 1'b0);
    stall("to15", 10'd46, 8'd0, 1'b1);
    simple("sticky_inc", 3'd1, 10'd0, 10'd47, 1'b1);
    simple("sticky_fetch", 3'd0, 10'd0, 10'd1, 1'b1);
    step("clr", 1'b1, 3'd1, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 8'd0, 1'b0);

    // MFC arriving on the timeout cycle wins
    simple("j2m", 3'd2, 10'd2, 10'd2, 1'b0);
    for (int i = 1; i <= 14; i++) stall($sformatf("tm%0d", i), 10'd2, 8'(i), 1'b0);
    step("tm15", 1'b0, 3'd4, 10'd0, 1'b0, 1'b0, 1'b1, 32'h0, 10'd3, 8'd0, 1'b0);

    // Address wrap
    simple("j1023", 3'd2, 10'd1023, 10'd1023, 1'b0);
    simple("wrap", 3'd1, 10'd0, 10'd0, 1'b0);

    // Reset while stalled
    simple("j5", 3'd2, 10'd5, 10'd5, 1'b0);
    for (int i = 1; i <= 7; i++) stall($sformatf("rw%0d", i), 10'd5, 8'(i), 1'b0);
    step("rst_wait", 1'b1, 3'd4, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 8'd0, 1'b0);

    check_val("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
